// File: rtl/osd_trace_arbiter.sv
// osd_trace_arbiter
//   Shares one trace packetizer between NUM_SRC trace sources. Tracers cannot
//   be stalled, so each source owns a one-entry holding register and a
//   saturating 10-bit drop counter. Drops are reported as an overflow
//   request that carries the count. Requests are granted round-robin, and a
//   grant is held until the packetizer accepts it.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   id            base id; out_id = id + granted source index (mod 2^10)
//   in_data       source i payload at [i*WIDTH +: WIDTH]
//   in_valid      single-cycle event strobe per source (no backpressure)
//   out_data      trace_data to packetizer
//   out_overflow  trace_overflow to packetizer
//   out_valid     trace_valid to packetizer
//   out_ready     trace_ready from packetizer
//   out_id        packetizer id
//   out_src       granted source index
module osd_trace_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int WIDTH   = 32,
  parameter int SW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [9:0]               id,
  input  logic [NUM_SRC*WIDTH-1:0] in_data,
  input  logic [NUM_SRC-1:0]       in_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [9:0]               out_id,
  output logic [SW-1:0]            out_src
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] hold_valid;
  logic [WIDTH-1:0]   hold_data [NUM_SRC];
  logic [9:0]         ovf_cnt   [NUM_SRC];
  logic [SW-1:0]      grant_src;
  logic               grant_ovf;
  logic [SW-1:0]      last_src;
  logic [SW-1:0]      sel_src;
  logic               sel_found;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] evt_acc;
  logic [NUM_SRC-1:0] ovf_acc;
  logic [NUM_SRC-1:0] free;
  logic               xfer;

  function automatic logic [9:0] sat_inc(input logic [9:0] c);
    return (c == 10'h3FF) ? c : c + 10'd1;
  endfunction

  function automatic logic [WIDTH-1:0] cnt_to_data(input logic [9:0] c);
    logic [WIDTH-1:0] v;
    v      = '0;
    v[9:0] = c;
    return v;
  endfunction

  assign xfer = (state == GRANT) && out_ready;

  // Request and acceptance decode per source
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      req[i]     = hold_valid[i] || (ovf_cnt[i] != '0);
      evt_acc[i] = xfer && (grant_src == SW'(i)) && !grant_ovf;
      ovf_acc[i] = xfer && (grant_src == SW'(i)) && grant_ovf;
      // A strobe may only be captured if nothing older is left pending,
      // which keeps held event -> overflow report -> newer events in order.
      free[i]    = (!hold_valid[i] || evt_acc[i]) &&
                   ((ovf_cnt[i] == '0) || ovf_acc[i]);
    end
  end

  // Round-robin pick, scanning from the source after the last grant
  always_comb begin
    sel_found = 1'b0;
    sel_src   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!sel_found && req[SW'((int'(last_src) + k) % NUM_SRC)]) begin
        sel_found = 1'b1;
        sel_src   = SW'((int'(last_src) + k) % NUM_SRC);
      end
    end
  end

  // Per-source holding register and drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= '0;
      for (int i = 0; i < NUM_SRC; i++) ovf_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (in_valid[i] && free[i]) hold_valid[i] <= 1'b1;
        else if (evt_acc[i])        hold_valid[i] <= 1'b0;

        if (ovf_acc[i])                  ovf_cnt[i] <= '0;
        else if (in_valid[i] && !free[i]) ovf_cnt[i] <= sat_inc(ovf_cnt[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (in_valid[i] && free[i]) hold_data[i] <= in_data[i*WIDTH +: WIDTH];
    end
  end

  // Grant state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_src <= '0;
      grant_ovf <= 1'b0;
      last_src  <= SW'(NUM_SRC - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && sel_found) begin
        grant_src <= sel_src;
        // Request type is frozen here and never re-evaluated while granted
        grant_ovf <= !hold_valid[sel_src];
      end
      if (xfer) last_src <= grant_src;
    end
  end

  always_comb begin
    state_nxt    = state;
    out_valid    = 1'b0;
    out_overflow = 1'b0;
    out_data     = '0;
    case (state)
      IDLE: begin
        if (sel_found) state_nxt = GRANT;
      end
      GRANT: begin
        out_valid    = 1'b1;
        out_overflow = grant_ovf;
        // Overflow reports follow the live count, which can still grow
        out_data     = grant_ovf ? cnt_to_data(ovf_cnt[grant_src])
                                 : hold_data[grant_src];
        if (out_ready) state_nxt = IDLE;
      end
    endcase
  end

  assign out_src = grant_src;
  assign out_id  = id + {{(10-SW){1'b0}}, grant_src};

endmodule

// File: doc/osd_trace_arbiter.md
Name: osd_trace_arbiter

Overview:
- Shares one trace packetizer (data/overflow/valid/ready trace interface) between NUM_SRC independent trace sources.
- Tracers cannot be stalled. Each source has a one-entry holding register and a saturating 10-bit drop counter.
- Drops are reported as an overflow (status) request carrying the count. Round-robin grants are held stable until the packetizer accepts.
- Sits between the per-core/per-event tracers and the packetizer in a debug module.

Parameters:
- NUM_SRC, 4, number of trace sources (1..16).
- WIDTH, 32, trace event payload width (≥10).
- SW, $clog2(NUM_SRC) (1 if NUM_SRC=1), source index width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id  in  10  base id; out_id = id + selected source index (mod 2^10)
- in_data  in  NUM_SRC*WIDTH  source i payload at [i*WIDTH +: WIDTH]
- in_valid  in  NUM_SRC  single-cycle event strobe per source, no backpressure
- out_data  out  WIDTH  to packetizer trace_data
- out_overflow  out  1  to packetizer trace_overflow
- out_valid  out  1  to packetizer trace_valid
- out_ready  in  1  from packetizer trace_ready
- out_id  out  10  to packetizer id
- out_src  out  SW  granted source index

Behaviour:
- Reset values: all hold_valid 0, all ovf_cnt 0, state IDLE, out_valid 0, out_overflow 0, out_data 0, out_id = id, out_src 0, last-grant pointer NUM_SRC-1 (so source 0 wins first).
- Per-source request:
  - event if hold_valid[i];
  - else overflow if ovf_cnt[i]≠0;
  - else none.
  - Ordering guarantee per source: held event, then overflow report, then newer events.
- Per-source capture (evaluated each cycle an in_valid[i] strobe arrives):
  - "free" = (hold_valid[i]=0 or its event is accepted this cycle) AND (ovf_cnt[i]=0 or its overflow report is accepted this cycle).
  - free: load hold_data[i], set hold_valid[i].
  - otherwise: drop the event; ovf_cnt[i] += 1, saturating at 1023.
- Overflow accept cycle: ovf_cnt[i] is cleared; a same-cycle strobe is captured, not counted.
- Event accept and drop in the same cycle (ovf_cnt≠0): the event clears and the drop increments.
- FSM IDLE:
  - If any request exists, pick the first requesting source scanning from pointer+1 with wrap.
  - Register grant index and type, go to GRANT.
  - out_valid=0 in IDLE.
- FSM GRANT:
  - out_valid=1.
  - out_overflow=1 for an overflow grant, else 0.
  - out_data = hold_data[g] for an event grant; {zeros, ovf_cnt[g]} for an overflow grant.
  - Outputs stay stable while out_ready=0, except on an overflow grant: out_data[9:0] tracks the live ovf_cnt[g], which may still increment.
  - On out_valid & out_ready: release source g (clear hold_valid or ovf_cnt), set pointer=g, return to IDLE.
- Latency: strobe in cycle N → hold valid N+1 → out_valid earliest N+2.
- Throughput: one transfer per 2 cycles, which is sufficient because the packetizer spends ≥3 cycles per packet.
- out_ready while out_valid=0 is ignored.
- Granted request type is fixed at grant time and is never re-evaluated in GRANT.
- Async reset mid-GRANT: out_valid drops immediately; all pending events and counts are lost; no partial state survives.

Test Plan:
- Single event: in_valid[2]=1, in_data src2=0xDEADBEEF, id=0x040, out_ready=1 → two cycles later out_valid=1, out_data=0xDEADBEEF, out_overflow=0, out_id=0x042, out_src=2; then out_valid=0.
- Simultaneous: strobe sources 0,1,3 in one cycle, out_ready=1 → grants in order 0,1,3. Repeat with pointer at 1 → order 3,0,1.
- Overflow: out_ready=0, src1 event A then 3 more strobes → after release, A is emitted, then out_overflow=1 with out_data[9:0]=3, then ovf_cnt=0.
- Saturation: hold src0 full, 1100 strobes → overflow report value 1023.
- Boundary: src0 strobe in the same cycle its overflow report is accepted → next src0 request is an event carrying that payload, count 0. Strobe in the same cycle its event is accepted while ovf_cnt=0 → captured.
- Reset: assert rst asynchronously during GRANT with out_ready=0 → out_valid=0 without a clock edge. After release with no strobes → out_valid stays 0; first later grant goes to source 0.
